// File: rtl/debouncer_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    DB_STABLE  = 2'd0,
    DB_QUALIFY = 2'd1,
    DB_LOCK    = 2'd2
  } db_state_t;

  localparam int DB_MODE_INTEGRATE = 0;
  localparam int DB_MODE_LOCKOUT   = 1;

  localparam int GLITCH_CNT_W = 8;
  typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, integrate/lockout FSM, edge pulses.
// Optional per-channel glitch counter when DEBOUNCE_GLITCH_CNT_EN is defined.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MODE          = DB_MODE_INTEGRATE,
  parameter bit RESET_LEVEL   = 1'b0,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rstN,
  input  logic value_in,
  output logic value_out,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic        glitch_clr,
  output glitch_cnt_t glitch_cnt
`endif
);

  localparam bit               LOCKOUT  = (MODE == DB_MODE_LOCKOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  db_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             out_n;
  logic             rise_n;
  logic             fall_n;
  logic             differ;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync_p0 <= RESET_LEVEL;
      sync_p1 <= RESET_LEVEL;
    end else begin
      sync_p0 <= value_in;
      sync_p1 <= sync_p0;
    end
  end

  assign differ = (sync_p1 != value_out);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    out_n   = value_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (LOCKOUT) begin
      // Lockout: follow the first change at once, then blank for STABLE_CYCLES.
      case (state)
        DB_STABLE: begin
          cnt_n = '0;
          if (differ) begin
            out_n   = sync_p1;
            rise_n  = sync_p1;
            fall_n  = !sync_p1;
            state_n = DB_LOCK;
          end
        end
        DB_LOCK: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = DB_STABLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = DB_STABLE;
        end
      endcase
    end else begin
      // Integrate: the new level must hold for STABLE_CYCLES before it is taken.
      case (state)
        DB_STABLE: begin
          if (differ) begin
            cnt_n   = CNT_W'(1);
            state_n = DB_QUALIFY;
          end else begin
            cnt_n = '0;
          end
        end
        DB_QUALIFY: begin
          if (!differ) begin
            cnt_n   = '0;
            state_n = DB_STABLE;
          end else if (cnt == CNT_LAST) begin
            out_n   = sync_p1;
            rise_n  = sync_p1;
            fall_n  = !sync_p1;
            cnt_n   = '0;
            state_n = DB_STABLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = DB_STABLE;
        end
      endcase
    end
  end

  // Stage p2: debounced level and its edge pulses
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= DB_STABLE;
      cnt        <= '0;
      value_out  <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      value_out  <= out_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic        sync_p2;
  logic        glitch_ev;
  glitch_cnt_t gcnt;

  function automatic glitch_cnt_t sat_inc(input glitch_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A glitch is an aborted qualification, or any input toggle while blanked.
  always_comb begin
    glitch_ev = 1'b0;
    if (LOCKOUT) begin
      glitch_ev = (state == DB_LOCK) && (sync_p1 != sync_p2);
    end else begin
      glitch_ev = (state == DB_QUALIFY) && !differ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync_p2 <= RESET_LEVEL;
      gcnt    <= '0;
    end else begin
      sync_p2 <= sync_p1;
      if (glitch_clr) begin
        gcnt <= '0;
      end else if (glitch_ev) begin
        gcnt <= sat_inc(gcnt);
      end
    end
  end

  assign glitch_cnt = gcnt;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// CHANNELS independent debouncers sharing one mode and interval.
// Define DEBOUNCE_GLITCH_CNT_EN to add glitch_clr / glitch_cnt per channel.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int DELAY_MS      = 20,
  parameter int STABLE_CYCLES = DELAY_MS * CLK_FREQ_MHZ * 1000,
  parameter int MODE          = DB_MODE_INTEGRATE,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CHANNELS-1:0] value_in,
  output logic [CHANNELS-1:0] value_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic                             glitch_clr,
  output logic [CHANNELS*GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
  // Any non-integrate setting selects lockout.
  localparam int MODE_SEL = (MODE == DB_MODE_INTEGRATE) ? DB_MODE_INTEGRATE : DB_MODE_LOCKOUT;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .MODE          (MODE_SEL),
      .RESET_LEVEL   (RESET_LEVEL),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rstN       (rstN),
      .value_in   (value_in[i]),
      .value_out  (value_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt[GLITCH_CNT_W*i +: GLITCH_CNT_W])
`endif
    );
  end

endmodule
